// File: rtl/vector_store_memory_pkg.sv
// rtl/vector_store_memory_pkg.sv - shared types, depth helper and pixel saturation for the vector store memory
package vector_mem_pkg;

   typedef logic [15:0] lane_t;
   typedef lane_t [15:0] vec_t;
   typedef logic [7:0]  pix_t;

   typedef enum logic [1:0] {IDLE, WRITE, FIN} store_state_t;

   function automatic int mem_depth(input int width, input int height);
      return width * height;
   endfunction

   // Lanes are signed 16-bit; clamp to the unsigned 8-bit pixel range.
   function automatic pix_t sat_u8(input lane_t v);
      if (v[15])
         return 8'h00;
      else if (v[14:8] != 7'd0)
         return 8'hFF;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/vector_store_memory_if.sv
// rtl/vector_store_memory_if.sv - store request, status and readout signals of the vector store memory
interface vector_store_memory_if;
   import vector_mem_pkg::*;

   logic        WE;
   logic [15:0] Addr;
   vec_t        WD;
   logic        BUSY;
   logic        DONE;
   logic        OOR;
   logic [15:0] RdAddr;
   pix_t        RdData;

   modport master (
      output WE, Addr, WD, RdAddr,
      input  BUSY, DONE, OOR, RdData
   );

   modport slave (
      input  WE, Addr, WD, RdAddr,
      output BUSY, DONE, OOR, RdData
   );
endinterface

// File: rtl/vector_store_memory_image_byte_ram.sv
// rtl/vector_store_memory_image_byte_ram.sv - byte-wide simple dual-port RAM, registered read-before-write port
module image_byte_ram #(
   parameter int DEPTH = 9216,
   parameter int DW    = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [15:0]   raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [DEPTH] = '{default: '0};
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i)
         mem[waddr_i] <= wdata_i;
   end

   // Non-blocking read of the same array gives the pre-write byte on a collision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         rdata_q <= '0;
      else if (int'(raddr_i) < DEPTH)
         rdata_q <= mem[raddr_i[AW-1:0]];
      else
         rdata_q <= '0;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_store_memory.sv
// rtl/vector_store_memory.sv - saturating vector store, writing LANES pixels serially into a byte image RAM
module vector_store_memory
   import vector_mem_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 96,
   parameter int IMAGE_HEIGHT = 96,
   parameter int PIX_SIZE     = 8,
   parameter int LANES        = 8
) (
   input logic                  CLK,
   input logic                  RST_N,
   vector_store_memory_if.slave bus
);

   localparam int             DEPTH = mem_depth(IMAGE_WIDTH, IMAGE_HEIGHT);
   localparam int             AW    = $clog2(DEPTH);
   localparam logic [3:0]     LAST  = 4'(LANES - 1);

   store_state_t state_q, state_d;
   logic [15:0]  base_q, base_d;
   pix_t [15:0]  lane_buf_q, lane_buf_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         oor_q, oor_d;

   logic [16:0]  wr_addr;
   logic         in_range;
   logic         wr_en;

   // 17-bit sum so a base near 0xFFFF never wraps back onto low addresses.
   assign wr_addr  = {1'b0, base_q} + {13'd0, cnt_q};
   assign in_range = int'(wr_addr) < DEPTH;
   assign wr_en    = (state_q == WRITE) && in_range;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         base_q     <= '0;
         lane_buf_q <= '0;
         cnt_q      <= '0;
         oor_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         lane_buf_q <= lane_buf_d;
         cnt_q      <= cnt_d;
         oor_q      <= oor_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      lane_buf_d = lane_buf_q;
      cnt_d      = cnt_q;
      oor_d      = oor_q;
      unique case (state_q)
         IDLE: begin
            if (bus.WE) begin
               base_d = bus.Addr;
               for (int i = 0; i < 16; i++)
                  lane_buf_d[i] = (i < LANES) ? sat_u8(bus.WD[i]) : 8'h00;
               oor_d   = 1'b0;
               cnt_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (!in_range)
               oor_d = 1'b1;
            if (cnt_q == LAST)
               state_d = FIN;
            else
               cnt_d = cnt_q + 4'd1;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.BUSY = (state_q != IDLE);
   assign bus.DONE = (state_q == FIN);
   assign bus.OOR  = (state_q == FIN) && oor_q;

   image_byte_ram #(
      .DEPTH (DEPTH),
      .DW    (PIX_SIZE)
   ) u_ram (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .we_i    (wr_en),
      .waddr_i (wr_addr[AW-1:0]),
      .wdata_i (lane_buf_q[cnt_q]),
      .raddr_i (bus.RdAddr),
      .rdata_o (bus.RdData)
   );

endmodule
